// File: rtl/dram_burst_model.sv
// dram_burst_model: DRAM model with burst reads, wrap, configurable read latency and valid/last/ready handshake.
// Define DRAM_BURST_CONST_FILL_EN to return FILL_VALUE on every beat instead of array contents.
module dram_burst_model #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W = 4,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE = 'h0101
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [LEN_W-1:0]  i_rd_len,
  output logic              o_rd_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DRAM_BURST_CONST_FILL_EN
  localparam bit CONST_FILL = 1'b1;
`else
  localparam bit CONST_FILL = 1'b0;
`endif
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [LEN_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_lst;
  logic [DATA_W-1:0] r_dat [RD_LAT];
  logic w_accept;
  logic w_issue;
  logic w_last;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_beat;
  assign o_rd_ready = (r_state == IDLE);
  assign w_accept = i_rd_req & o_rd_ready;
  assign w_issue = w_accept | (r_state == BURST);
  assign w_last = w_accept ? (i_rd_len == '0) : (r_remaining == LEN_W'(1));
  assign w_rd_addr = w_accept ? i_rd_addr : r_addr_cnt;
  // The read at issue time sees the array before this edge's write, giving read-first behaviour.
  assign w_beat = CONST_FILL ? FILL_VALUE : r_mem[w_rd_addr];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_addr_cnt <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      if (i_rd_len != '0) begin
        r_state <= BURST;
        r_addr_cnt <= i_rd_addr + 1'b1;
        r_remaining <= i_rd_len;
      end
    end else if (r_state == BURST) begin
      r_addr_cnt <= r_addr_cnt + 1'b1;
      r_remaining <= r_remaining - 1'b1;
      if (r_remaining == LEN_W'(1)) r_state <= IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_lst <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_lst[0] <= w_issue & w_last;
      r_dat[0] <= w_issue ? w_beat : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end
  assign o_rd_valid = r_vld[RD_LAT-1];
  assign o_rd_last = r_lst[RD_LAT-1];
  assign o_rd_data = r_dat[RD_LAT-1];
endmodule
